uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver: 8N1, LSB first; sys_clk domain.
- Takes the asynchronous serial line `rx`, synchronises it and validates the start bit at mid-bit.
- Samples each data and stop bit at its centre and presents the byte with a one-cycle valid pulse.
- Feeds the host command/image-byte path. Pairs with the team's uart_tx, whose `pi_data`/`pi_flag` format it mirrors.

Parameters:
- UART_BPS, 115200: serial baud rate.
- CLK_FREQ, 50_000_000: sys_clk frequency in Hz.
- Derived localparams: BAUD_CNT_MAX = CLK_FREQ / UART_BPS (integer, 434 at defaults); HALF_BIT = BAUD_CNT_MAX / 2 (217).
- Legal only when BAUD_CNT_MAX >= 8. Baud counter is 16 bits wide.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  reset, synchronous, active-high.
- rx  input  1  asynchronous serial line; idle high.
- po_data  output  8  received byte; held stable until the next po_flag.
- po_flag  output  1  one-cycle pulse: po_data valid, frame good.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous and active-high. On sys_rst asserted at a sys_clk edge:
  - state = IDLE; all counters = 0.
  - Synchroniser flops and the previous-sample register are set to 1.
  - po_data = 8'h00; po_flag = 0; frame_err = 0; busy = 0.
- Reset mid-frame aborts the frame immediately. No po_flag or frame_err is produced for that frame.
- Input conditioning:
  - 2-flop synchroniser: rx -> rx_s1 -> rx_s2.
  - rx_s3 is the registered previous value of rx_s2.
  - Falling edge = rx_s3 & ~rx_s2.
- Baud counter:
  - Counts 0..BAUD_CNT_MAX-1 and wraps to 0.
  - Cleared to 0 in IDLE and on every state change.
- FSM:
  - IDLE: on a falling edge, go to START with baud_cnt = 0.
  - START: when baud_cnt == HALF_BIT-1, sample rx_s2.
    - 1: glitch. Return to IDLE; no output.
    - 0: go to DATA with baud_cnt = 0 and bit_idx = 0. This re-phases sampling to mid-bit.
  - DATA: when baud_cnt == BAUD_CNT_MAX-1, shift rx_s2 into shift_reg[bit_idx] (LSB first) and increment bit_idx.
    - After bit_idx 7 is sampled, go to STOP.
  - STOP: when baud_cnt == BAUD_CNT_MAX-1, sample rx_s2.
    - 1: po_data <= shift_reg and po_flag <= 1 for exactly the next cycle.
    - 0: frame_err <= 1 for one cycle; po_data is unchanged.
    - Either way, go to IDLE.
- Latency: po_flag rises about 9.5 bit periods + 4 cycles after the rx falling edge (2-flop sync + edge detect + output register).
- Re-arming: IDLE arms only on a falling edge. A line held low after a framing error (break) produces no further frames until rx returns high and then falls again.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit period for detection, so a start bit immediately after the stop bit is captured.
- po_flag and frame_err are never high in the same cycle. Each is high for exactly 1 cycle per frame.
- Baud tolerance: frames are received correctly with a sender baud error up to ±3%.

Test Plan:
- Reset release, rx high for 1000 cycles -> po_flag = 0, frame_err = 0, busy = 0, po_data = 8'h00.
- Send 0x55 at 115200 -> one po_flag pulse; po_data = 8'h55; busy falls in the same cycle as po_flag rises.
- Frames 0xA3, 0x00, 0xFF back-to-back with no idle gap -> three po_flag pulses, values in order, no frame_err.
- rx low for 100 cycles then high (glitch), then rx low for a full 10-bit frame time (break) -> first produces nothing; break gives exactly one frame_err, then no further pulses until a proper 0x3C frame yields po_flag with po_data = 8'h3C.
- Send 0x81 with the stop bit forced low -> frame_err pulse; po_flag stays 0; po_data retains its previous value.
- sys_rst pulsed during data bit 4 of 0xC6, then 0x5A sent -> no output for 0xC6; po_data = 8'h5A.
- 0x96 sent at baud +3% and at baud -3% -> po_data = 8'h96 in both cases.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: synchronised input, mid-bit sampling, valid/framing-error pulses
module uart_rx #(
  parameter int UART_BPS = 115200,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       busy
);

  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int          HALF_BIT     = BAUD_CNT_MAX / 2;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_s3;
  logic        rx_fall;
  logic [15:0] baud_cnt;
  logic        baud_end;
  logic        half_end;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;

  // Two-flop synchroniser plus previous-sample register; all idle-high so reset never fakes an edge on an idle line
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall  = rx_s3 & ~rx_s2;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign half_end = (baud_cnt == HALF_LAST);
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start bit confirmed at half a bit, then data and stop sampled one full bit apart (mid-bit)
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_fall) state_next = START;
      START:   if (half_end) state_next = rx_s2 ? IDLE : DATA;
      DATA:    if (baud_end && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (baud_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Baud counter restarts on every state change so each phase times from its own entry point
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      baud_cnt <= 16'd0;
    end else if ((state == IDLE) || (state_next != state) || baud_end) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Data bits shifted in LSB first at the centre of each bit
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (state != DATA) begin
      bit_idx <= 3'd0;
    end else if (baud_end) begin
      shift_reg[bit_idx] <= rx_s2;
      bit_idx            <= bit_idx + 3'd1;
    end
  end

  // Output register: a good stop bit publishes the byte, a low stop bit flags a framing error and keeps the old byte
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      if ((state == STOP) && baud_end) begin
        if (rx_s2) begin
          po_data <= shift_reg;
          po_flag <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 115200;
  localparam int BIT_CYC  = CLK_FREQ / UART_BPS;
  localparam int FAST_CYC = BIT_CYC * 100 / 103;
  localparam int SLOW_CYC = BIT_CYC * 100 / 97;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx      = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;
  logic       busy;

  int         tests    = 0;
  int         fails    = 0;
  int         flag_cnt = 0;
  int         err_cnt  = 0;
  logic       prev_flag = 1'b0;
  logic       prev_err  = 1'b0;
  logic       prev_busy = 1'b0;
  logic       flag_busy = 1'b1;
  logic       flag_prev_busy = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  uart_rx #(
    .UART_BPS(UART_BPS),
    .CLK_FREQ(CLK_FREQ)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 sys_clk = ~sys_clk;

  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        prev_flag = 1'b0;
        prev_err  = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (po_flag || frame_err) begin
          tests++;
          if ((po_flag && frame_err) !== 1'b0) begin
            fails++;
            $display("FAIL pulse_overlap: po_flag=%b frame_err=%b, required never both high", po_flag, frame_err);
          end
        end
        if (po_flag) begin
          flag_cnt++;
          flag_busy      = busy;
          flag_prev_busy = prev_busy;
          tests++;
          if (prev_flag !== 1'b0) begin
            fails++;
            $display("FAIL po_flag_width: po_flag high on consecutive cycles, required single-cycle pulse");
          end
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_unexpected: po_flag with po_data=%h, required no pulse", po_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (po_data !== exp_b) begin
              fails++;
              $display("FAIL scoreboard_data: po_data=%h, required %h", po_data, exp_b);
            end
          end
        end
        if (frame_err) begin
          err_cnt++;
          tests++;
          if (prev_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_err_width: frame_err high on consecutive cycles, required single-cycle pulse");
          end
        end
        prev_flag = po_flag;
        prev_err  = frame_err;
        prev_busy = busy;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic v, input int cyc);
    rx = v;
    idle(cyc);
  endtask

  task automatic send_byte(input logic [7:0] b, input int cyc, input logic stop_v);
    drive_bit(1'b0, cyc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], cyc);
    drive_bit(stop_v, cyc);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input int cyc);
    exp_q.push_back(b);
    send_byte(b, cyc, 1'b1);
  endtask

  task automatic test_reset;
    int f0;
    int e0;
    sys_rst = 1'b1;
    rx      = 1'b1;
    idle(5);
    sys_rst = 1'b0;
    f0 = flag_cnt;
    e0 = err_cnt;
    idle(1000);
    tests++;
    if (po_flag !== 1'b0) begin fails++; $display("FAIL reset_po_flag: got %b, required 0", po_flag); end
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++;
    if (po_data !== 8'h00) begin fails++; $display("FAIL reset_po_data: got %h, required 00", po_data); end
    tests++;
    if ((flag_cnt - f0) !== 0 || (err_cnt - e0) !== 0) begin
      fails++;
      $display("FAIL reset_idle_pulses: flags=%0d errs=%0d, required 0 and 0", flag_cnt - f0, err_cnt - e0);
    end
  endtask

  task automatic test_single;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    send_good(8'h55, BIT_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 1) begin fails++; $display("FAIL single_flag_count: got %0d, required 1", flag_cnt - f0); end
    tests++;
    if ((err_cnt - e0) !== 0) begin fails++; $display("FAIL single_err_count: got %0d, required 0", err_cnt - e0); end
    tests++;
    if (po_data !== 8'h55) begin fails++; $display("FAIL single_po_data: got %h, required 55", po_data); end
    tests++;
    if (flag_busy !== 1'b0 || flag_prev_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_busy_edge: busy at flag=%b, before=%b, required 0 and 1", flag_busy, flag_prev_busy);
    end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL single_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    send_good(8'hA3, BIT_CYC);
    send_good(8'h00, BIT_CYC);
    send_good(8'hFF, BIT_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 3) begin fails++; $display("FAIL b2b_flag_count: got %0d, required 3", flag_cnt - f0); end
    tests++;
    if ((err_cnt - e0) !== 0) begin fails++; $display("FAIL b2b_err_count: got %0d, required 0", err_cnt - e0); end
    tests++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_glitch_break;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 2 * BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 0 || (err_cnt - e0) !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_ignored: flags=%0d errs=%0d busy=%b, required 0 0 0", flag_cnt - f0, err_cnt - e0, busy);
    end
    drive_bit(1'b0, 10 * BIT_CYC);
    tests++;
    if ((err_cnt - e0) !== 1) begin fails++; $display("FAIL break_err_count: got %0d, required 1", err_cnt - e0); end
    drive_bit(1'b1, 3 * BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 0 || (err_cnt - e0) !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL break_quiet: flags=%0d errs=%0d busy=%b, required 0 1 0", flag_cnt - f0, err_cnt - e0, busy);
    end
    send_good(8'h3C, BIT_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 1) begin fails++; $display("FAIL rearm_flag_count: got %0d, required 1", flag_cnt - f0); end
    tests++;
    if (po_data !== 8'h3C) begin fails++; $display("FAIL rearm_po_data: got %h, required 3c", po_data); end
  endtask

  task automatic test_stop_low;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    send_byte(8'h81, BIT_CYC, 1'b0);
    idle(BIT_CYC);
    tests++;
    if ((err_cnt - e0) !== 1) begin fails++; $display("FAIL stoplow_err_count: got %0d, required 1", err_cnt - e0); end
    tests++;
    if ((flag_cnt - f0) !== 0) begin fails++; $display("FAIL stoplow_flag_count: got %0d, required 0", flag_cnt - f0); end
    tests++;
    if (po_data !== 8'h3C) begin fails++; $display("FAIL stoplow_po_data: got %h, required 3c", po_data); end
  endtask

  task automatic test_reset_midframe;
    int f0;
    int e0;
    logic [7:0] b;
    b  = 8'hC6;
    f0 = flag_cnt;
    e0 = err_cnt;
    drive_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CYC);
    drive_bit(b[4], BIT_CYC / 2);
    sys_rst = 1'b1;
    idle(2);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    // Reset is held while the line is still low so release does not see a start edge
    idle(BIT_CYC - BIT_CYC / 2 - 2);
    drive_bit(b[5], BIT_CYC);
    sys_rst = 1'b0;
    drive_bit(b[6], BIT_CYC);
    drive_bit(b[7], BIT_CYC);
    drive_bit(1'b1, 2 * BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 0 || (err_cnt - e0) !== 0) begin
      fails++;
      $display("FAIL midreset_no_output: flags=%0d errs=%0d, required 0 0", flag_cnt - f0, err_cnt - e0);
    end
    send_good(8'h5A, BIT_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 1) begin fails++; $display("FAIL midreset_next_count: got %0d, required 1", flag_cnt - f0); end
    tests++;
    if (po_data !== 8'h5A) begin fails++; $display("FAIL midreset_po_data: got %h, required 5a", po_data); end
  endtask

  task automatic test_baud_tolerance;
    int f0;
    int e0;
    f0 = flag_cnt;
    e0 = err_cnt;
    send_good(8'h96, FAST_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 1 || po_data !== 8'h96) begin
      fails++;
      $display("FAIL baud_fast: flags=%0d po_data=%h, required 1 96", flag_cnt - f0, po_data);
    end
    send_good(8'h96, SLOW_CYC);
    idle(BIT_CYC);
    tests++;
    if ((flag_cnt - f0) !== 2 || po_data !== 8'h96) begin
      fails++;
      $display("FAIL baud_slow: flags=%0d po_data=%h, required 2 96", flag_cnt - f0, po_data);
    end
    tests++;
    if ((err_cnt - e0) !== 0 || exp_q.size() !== 0) begin
      fails++;
      $display("FAIL baud_clean: errs=%0d pending=%0d, required 0 0", err_cnt - e0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch_break();
    test_stop_low();
    test_reset_midframe();
    test_baud_tolerance();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
